// File: rtl/line_fetcher_if.sv
// axi3_rd_if: AXI3 read address and read data channels, master and slave views.
interface axi3_rd_if #(
    parameter int unsigned BUS_WIDTH = 4
);
    logic [BUS_WIDTH-1:0] arid;
    logic [31:0]          araddr;
    logic [3:0]           arlen;
    logic [2:0]           arsize;
    logic [1:0]           arburst;
    logic                 arvalid;
    logic                 arready;
    logic [BUS_WIDTH-1:0] rid;
    logic [31:0]          rdata;
    logic [1:0]           rresp;
    logic                 rlast;
    logic                 rvalid;
    logic                 rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/line_fetcher.sv
// line_fetcher: AXI3 read-burst master that refills one cache line per request.
// Define CRITICAL_WORD_FIRST_EN for a wrapping burst starting at the missed word (crit_word/crit_vld).
module line_fetcher #(
    parameter int unsigned LINE_WIDTH = 256,
    parameter int unsigned ARID       = 2,
    parameter int unsigned BUS_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [31:0]           req_addr,
    output logic                  req_ready,
    output logic [LINE_WIDTH-1:0] line_data,
    output logic                  line_vld,
    output logic                  line_err,
    output logic                  busy,
`ifdef CRITICAL_WORD_FIRST_EN
    output logic [31:0]           crit_word,
    output logic                  crit_vld,
`endif
    axi3_rd_if.master             axi
);
    localparam int unsigned BEATS            = LINE_WIDTH / 32;
    localparam int unsigned LINE_BYTE_OFFSET = $clog2(LINE_WIDTH / 8);
    localparam int unsigned SW               = $clog2(BEATS);
    localparam int unsigned CW               = $clog2(BEATS + 1);
    localparam logic [BUS_WIDTH-1:0] ARID_V  = BUS_WIDTH'(ARID);
    localparam logic [1:0] BURST_INCR        = 2'b01;
    localparam logic [1:0] BURST_WRAP        = 2'b10;
    localparam logic [1:0] RESP_OKAY         = 2'b00;

    typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_t;

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [SW-1:0] ptr_q, ptr_start;
    logic [CW-1:0] cnt_q;
    logic          err_q;
    logic          take, beat, id_ok, full, accept, beat_err;

    assign take = (state_q == StIdle) && req;

`ifdef CRITICAL_WORD_FIRST_EN
    assign addr_d      = {req_addr[31:2], 2'b00};
    assign ptr_start   = req_addr[LINE_BYTE_OFFSET-1:2];
    assign axi.arburst = BURST_WRAP;
    assign crit_word   = axi.rdata;
    assign crit_vld    = accept && (cnt_q == '0);
`else
    assign addr_d      = {req_addr[31:LINE_BYTE_OFFSET], {LINE_BYTE_OFFSET{1'b0}}};
    assign ptr_start   = '0;
    assign axi.arburst = BURST_INCR;
`endif

    // cnt_q counts accepted beats (completion rules); ptr_q is the line slot they land in.
    assign beat     = axi.rvalid && axi.rready;
    assign id_ok    = (axi.rid == ARID_V);
    assign full     = (cnt_q == CW'(BEATS));
    assign accept   = beat && id_ok && !full;
    assign beat_err = beat && ((axi.rresp != RESP_OKAY) || !id_ok || full ||
                               (axi.rlast && (cnt_q < CW'(BEATS - 1))));

    assign req_ready   = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign line_vld    = (state_q == StDone);
    assign line_err    = line_vld && err_q;
    assign axi.arvalid = (state_q == StAddr);
    assign axi.rready  = (state_q == StData);
    assign axi.arid    = ARID_V;
    assign axi.araddr  = addr_q;
    assign axi.arlen   = 4'(BEATS - 1);
    assign axi.arsize  = 3'b010;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req) state_d = StAddr;
            StAddr:  if (axi.arready) state_d = StData;
            StData:  if (axi.rvalid && axi.rlast) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            line_data <= '0;
        end else begin
            if (take) begin
                addr_q <= addr_d;
                ptr_q  <= ptr_start;
            end
            if (beat_err) begin
                err_q <= 1'b1;
            end
            if (accept) begin
                for (int k = 0; k < BEATS; k++) begin
                    if (ptr_q == SW'(k)) begin
                        line_data[32*k +: 32] <= axi.rdata;
                    end
                end
                ptr_q <= (ptr_q == SW'(BEATS - 1)) ? '0 : ptr_q + 1'b1;
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == StDone) begin
                err_q <= 1'b0;
                cnt_q <= '0;
            end
        end
    end
endmodule

// File: tb/tb_line_fetcher.sv
// tb_line_fetcher: randomized fetches against an identity-memory AXI3 slave,
// with a queue-based scoreboard fed by a line-level reference model.
module tb_line_fetcher;
    localparam int BEATS = 8;
    localparam int LB    = 32;
    localparam logic [3:0] ARID = 4'd2;
`ifdef CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
    logic [31:0] crit_word;
    logic        crit_vld;
`else
    localparam bit CWF = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        int          mode;     // 0 ok, 1 slverr, 2 early rlast, 3 bad rid, 4 extra beat
        int          e;
        int          ar_stall;
        int          rv_mode;  // 0 always, 1 toggle, 2 random
    } cfg_t;
    typedef struct { logic [255:0] data; logic err; } exp_t;
    typedef struct { logic [31:0] data; logic [3:0] id; logic [1:0] resp; logic last; } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req = 1'b0;
    logic [31:0]  req_addr = '0;
    logic         req_ready, line_vld, line_err, busy;
    logic [255:0] line_data;

    cfg_t        cfg_q[$];
    exp_t        exp_q[$];
    logic [31:0] crit_q[$];
    int          vld_cycs[$];
    logic [31:0] model_line[BEATS];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int beats_done = 0;

    axi3_rd_if #(.BUS_WIDTH(4)) bus ();

    line_fetcher #(.LINE_WIDTH(256), .ARID(2), .BUS_WIDTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_addr(req_addr),
        .req_ready(req_ready),
        .line_data(line_data),
        .line_vld(line_vld),
        .line_err(line_err),
        .busy(busy),
`ifdef CRITICAL_WORD_FIRST_EN
        .crit_word(crit_word),
        .crit_vld(crit_vld),
`endif
        .axi(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int vld_at(input int i);
        return (i < vld_cycs.size()) ? vld_cycs[i] : -1000;
    endfunction

    // Line-level model: beat i of a fetch fills slot (start+i) mod BEATS with that word's address.
    function automatic void model_push(input cfg_t c);
        exp_t x;
        int start, nwr, slot;
        logic [31:0] base;
        base  = c.addr & ~32'(LB - 1);
        start = CWF ? int'(c.addr[4:2]) : 0;
        nwr   = (c.mode == 2) ? c.e + 1 : BEATS;
        for (int i = 0; i < nwr; i++) begin
            slot = (start + i) % BEATS;
            model_line[slot] = base + 32'(slot * 4);
        end
        for (int k = 0; k < BEATS; k++) x.data[32*k +: 32] = model_line[k];
        x.err = (c.mode != 0);
        exp_q.push_back(x);
    endfunction

    task automatic issue(input logic [31:0] a, input int mode, input int e, input int ars,
                         input int rvm, input bit hold, input bit expect_line);
        cfg_t c;
        int t = 0;
        c.addr = a; c.mode = mode; c.e = e; c.ar_stall = ars; c.rv_mode = rvm;
        cfg_q.push_back(c);
        if (expect_line) model_push(c);
        crit_q.push_back(a & ~32'h3);
        req = 1'b1;
        req_addr = a;
        while (!req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL issue timeout: req_ready=%0b, expected 1", req_ready);
            req = 1'b0;
        end else begin
            acc_cyc = cyc;
            @(negedge clk);
            if (!hold) req = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || busy || cfg_q.size() != 0) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 1000) begin
            errors++;
            $display("FAIL wait_idle timeout: busy=%0b pending=%0d, expected idle", busy, exp_q.size());
        end
        @(negedge clk);
    endtask

    // Identity-memory slave: every beat returns its own byte address as data.
    initial begin : slave
        beat_t bq[$];
        beat_t b;
        cfg_t cur;
        bit hs_ar, hs_r, in_data, ar_busy, tog;
        int ar_cnt;
        logic [31:0] s_addr, exp_ar;
        logic [3:0] s_len;
        logic [1:0] s_burst;
        hs_ar = 0; hs_r = 0; in_data = 0; ar_busy = 0; tog = 1; ar_cnt = 0;
        s_addr = '0; s_len = '0; s_burst = '0;
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
        bus.rid = '0; bus.rresp = '0; bus.rlast = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.arready = 1'b0; bus.rvalid = 1'b0; bq.delete();
                hs_ar = 0; hs_r = 0; in_data = 0; ar_busy = 0;
            end else begin
                if (hs_r) begin
                    void'(bq.pop_front());
                    beats_done++;
                    if (bq.size() == 0) in_data = 0;
                end
                if (hs_ar) begin
                    int n, st;
                    logic [31:0] base, wsz, a;
                    n    = int'(s_len) + 1;
                    wsz  = 32'(n * 4);
                    base = s_addr & ~(wsz - 1);
                    st   = int'((s_addr - base) >> 2);
                    bq.delete();
                    for (int i = 0; i < n; i++) begin
                        a = (s_burst == 2'b10) ? base + 32'(((st + i) % n) * 4) : s_addr + 32'(i * 4);
                        b.data = a; b.id = ARID; b.resp = 2'b00; b.last = 1'b0;
                        bq.push_back(b);
                    end
                    case (cur.mode)
                        1: begin b = bq[cur.e]; b.resp = 2'b10; bq[cur.e] = b; end
                        2: while (bq.size() > cur.e + 1) void'(bq.pop_back());
                        3: begin
                            b.data = 32'hBAD0_0000; b.id = ~ARID; b.resp = 2'b00; b.last = 1'b0;
                            bq.insert(cur.e, b);
                        end
                        4: begin
                            b.data = 32'hDEAD_BEEF; b.id = ARID; b.resp = 2'b00; b.last = 1'b0;
                            bq.push_back(b);
                        end
                        default: ;
                    endcase
                    b = bq[bq.size() - 1];
                    b.last = 1'b1;
                    bq[bq.size() - 1] = b;
                    in_data = 1; tog = 1; beats_done = 0;
                end
                bus.arready = 1'b0;
                if (!in_data && bus.arvalid) begin
                    if (!ar_busy) begin
                        if (cfg_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected arvalid: araddr=%0h, expected no request", bus.araddr);
                        end else begin
                            cur = cfg_q.pop_front();
                            ar_cnt = cur.ar_stall;
                            ar_busy = 1;
                        end
                    end
                    if (ar_busy) begin
                        exp_ar = CWF ? (cur.addr & ~32'h3) : (cur.addr & ~32'(LB - 1));
                        check("araddr", bus.araddr, exp_ar);
                        check("arlen", bus.arlen, BEATS - 1);
                        check("arsize", bus.arsize, 3'b010);
                        check("arburst", bus.arburst, CWF ? 2'b10 : 2'b01);
                        check("arid", bus.arid, ARID);
                        if (ar_cnt > 0) begin
                            ar_cnt--;
                        end else begin
                            bus.arready = 1'b1;
                            s_addr = bus.araddr; s_len = bus.arlen; s_burst = bus.arburst;
                            ar_busy = 0;
                        end
                    end
                end
                bus.rvalid = 1'b0;
                if (in_data && bq.size() > 0) begin
                    b = bq[0];
                    bus.rdata = b.data; bus.rid = b.id; bus.rresp = b.resp; bus.rlast = b.last;
                    case (cur.rv_mode)
                        0: bus.rvalid = 1'b1;
                        1: begin bus.rvalid = tog; tog = ~tog; end
                        default: bus.rvalid = 1'($urandom_range(0, 1));
                    endcase
                end
                hs_ar = bus.arvalid && bus.arready;
                hs_r  = bus.rvalid && bus.rready;
            end
        end
    end

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            #1;
            if (line_vld) begin
                vld_cycs.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected line_vld: line_err=%0b, expected no pulse", line_err);
                end else begin
                    x = exp_q.pop_front();
                    check("line_data", line_data, x.data);
                    check("line_err", line_err, x.err);
                end
            end
`ifdef CRITICAL_WORD_FIRST_EN
            if (crit_vld) begin
                if (crit_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected crit_vld: crit_word=%0h, expected none", crit_word);
                end else begin
                    check("crit_word", crit_word, crit_q.pop_front());
                end
            end
`endif
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [255:0] single_line;
        int n0, a0, t, m, e;
        bit hold;
        for (int k = 0; k < BEATS; k++) model_line[k] = '0;
        for (int k = 0; k < BEATS; k++) single_line[32*k +: 32] = 32'h1220 + 32'(4 * k);
        repeat (2) @(negedge clk);
        check("rst req_ready", req_ready, 1'b1);
        check("rst line_vld", line_vld, 1'b0);
        check("rst line_err", line_err, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst line_data", line_data, '0);
        check("rst arvalid", bus.arvalid, 1'b0);
        check("rst rready", bus.rready, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // single fetch
        n0 = vld_cycs.size();
        issue(32'h0000_1234, 0, 0, 0, 0, 1'b0, 1'b1);
        a0 = acc_cyc;
        wait_idle();
        check("single pulses", vld_cycs.size() - n0, 1);
        check("single latency", vld_at(n0) - a0, BEATS + 2);
        check("single line", line_data, single_line);

        // stalls
        n0 = vld_cycs.size();
        issue(32'h0000_1234, 0, 0, 3, 1, 1'b0, 1'b1);
        wait_idle();
        check("stall pulses", vld_cycs.size() - n0, 1);
        check("stall line", line_data, single_line);

        // errors
        issue(32'h0000_1234, 1, 5, 0, 0, 1'b0, 1'b1);
        wait_idle();
        issue(32'h0000_2000, 2, 3, 0, 0, 1'b0, 1'b1);
        t = 0;
        while (!line_vld && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("early rlast vld", line_vld, 1'b1);
        @(negedge clk);
        check("early rlast req_ready", req_ready, 1'b1);
        wait_idle();

        // reset mid-burst
        n0 = vld_cycs.size();
        beats_done = 0;
        issue(32'h0000_0080, 0, 0, 0, 0, 1'b0, 1'b0);
        t = 0;
        while (beats_done < 4 && t < 100) begin
            @(negedge clk);
            t++;
        end
        #2 rst = 1'b1;
        #1;
        check("abort arvalid", bus.arvalid, 1'b0);
        check("abort rready", bus.rready, 1'b0);
        check("abort req_ready", req_ready, 1'b1);
        check("abort busy", busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < BEATS; k++) model_line[k] = '0;
        repeat (15) @(negedge clk);
        check("abort pulses", vld_cycs.size() - n0, 0);
        issue(32'h0000_0040, 0, 0, 0, 0, 1'b0, 1'b1);
        wait_idle();
        check("post-reset pulses", vld_cycs.size() - n0, 1);

        // back-to-back
        n0 = vld_cycs.size();
        issue(32'h0000_0000, 0, 0, 0, 0, 1'b1, 1'b1);
        issue(32'h0000_0020, 0, 0, 0, 0, 1'b1, 1'b1);
        issue(32'h0000_0040, 0, 0, 0, 0, 1'b0, 1'b1);
        wait_idle();
        check("b2b pulses", vld_cycs.size() - n0, 3);
        check("b2b spacing 1", vld_at(n0 + 1) - vld_at(n0), BEATS + 3);
        check("b2b spacing 2", vld_at(n0 + 2) - vld_at(n0 + 1), BEATS + 3);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            m = $urandom_range(0, 7);
            if (m > 4) m = 0;
            case (m)
                2:       e = $urandom_range(0, BEATS - 2);
                default: e = $urandom_range(0, BEATS - 1);
            endcase
            hold = (i < 39) ? 1'($urandom_range(0, 1)) : 1'b0;
            issue($urandom, m, e, $urandom_range(0, 3), $urandom_range(0, 2), hold, 1'b1);
            if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
